// File: rtl/titan_hazard_ctrl_pkg.sv
// Shared definitions for the Titan pipeline hazard controller.
// This covers the forward-select encodings, the FSM states, the stage control bundle and the register-match helper.
package titan_hazard_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FWD_W  = 2;

    // ID operand source select
    localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_TRAP     = 2'd2
    } hz_state_e;

    // One bit per pipeline stage register, IF..MEM
    typedef struct packed {
        logic if_s;
        logic id_s;
        logic ex_s;
        logic mem_s;
    } stage_ctl_t;

    // A later stage supplies the operand when it writes the same architectural register
    function automatic logic reg_match(input logic             we,
                                       input logic [REG_AW-1:0] waddr,
                                       input logic [REG_AW-1:0] rs);
        return we && (waddr == rs);
    endfunction

endpackage

// File: rtl/titan_fwd_sel.sv
// Operand forwarding select for one ID source register.
// The youngest producer wins: EX first, then MEM, then WB. x0 always reads the register file.
module titan_fwd_sel
    import titan_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] wb_waddr,
    input  logic              wb_we,
    output logic [FWD_W-1:0]  fwd_sel_c
);

    // Priority match against the in-flight destination registers
    always_comb begin
        fwd_sel_c = FWD_RF;
        if (rs != '0) begin
            if (reg_match(ex_we, ex_waddr, rs)) begin
                fwd_sel_c = FWD_EX;
            end else if (reg_match(mem_we, mem_waddr, rs)) begin
                fwd_sel_c = FWD_MEM;
            end else if (reg_match(wb_we, wb_waddr, rs)) begin
                fwd_sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/titan_hazard_ctrl.sv
// Titan 5-stage pipeline sequencer.
// It produces the ID forwarding selects and the per-stage stall and flush controls.
// It handles load-use bubbles, data-bus wait freezes, wrong-path fetch kill and the trap flush sequence.
// Optional: define TITAN_HAZARD_PERF_EN to add the saturating stall/flush performance counters.
module titan_hazard_ctrl
    import titan_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2
`ifdef TITAN_HAZARD_PERF_EN
    ,
    parameter int unsigned PERF_WIDTH = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic              ex_we_i,
    input  logic              ex_is_load_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] wb_waddr_i,
    input  logic              wb_we_i,
    input  logic              mem_busy_i,
    input  logic              take_branch_i,
    input  logic              take_jump_i,
    input  logic              exc_i,
    output logic [FWD_W-1:0]  forward_a_sel_o,
    output logic [FWD_W-1:0]  forward_b_sel_o,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              ex_stall_o,
    output logic              mem_stall_o,
    output logic              if_flush_o,
    output logic              id_flush_o,
    output logic              ex_flush_o,
    output logic              mem_flush_o,
    output logic              trap_redirect_o
`ifdef TITAN_HAZARD_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] stall_cnt_o,
    output logic [PERF_WIDTH-1:0] flush_cnt_o
`endif
);

    // trap_cnt holds the remaining TRAP-state cycles, at most TRAP_FLUSH_CYCLES-1
    localparam int unsigned     CNT_W      = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TRAP_LOAD = CNT_W'(TRAP_FLUSH_CYCLES - 1);
    localparam bit              TRAP_MULTI = (TRAP_FLUSH_CYCLES > 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    stage_ctl_t       stall_c, flush_c;
    logic             redirect_c;
    logic             ld_haz_c;

    // Operand forwarding, one selector per ID source
    titan_fwd_sel u_fwd_a (
        .rs        (id_rs1_i),
        .ex_waddr  (ex_waddr_i),
        .ex_we     (ex_we_i),
        .mem_waddr (mem_waddr_i),
        .mem_we    (mem_we_i),
        .wb_waddr  (wb_waddr_i),
        .wb_we     (wb_we_i),
        .fwd_sel_c (forward_a_sel_o)
    );

    titan_fwd_sel u_fwd_b (
        .rs        (id_rs2_i),
        .ex_waddr  (ex_waddr_i),
        .ex_we     (ex_we_i),
        .mem_waddr (mem_waddr_i),
        .mem_we    (mem_we_i),
        .wb_waddr  (wb_waddr_i),
        .wb_we     (wb_we_i),
        .fwd_sel_c (forward_b_sel_o)
    );

    // Load result is not available until MEM, so ID must wait one cycle
    assign ld_haz_c = ex_we_i && ex_is_load_i && (ex_waddr_i != '0) &&
                      ((ex_waddr_i == id_rs1_i) || (ex_waddr_i == id_rs2_i));

    // State and trap counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= HZ_RUN;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    // Next state and stall/flush decode, priority exc > bus wait > load-use > branch/jump
    always_comb begin
        state_d    = state_q;
        trap_cnt_d = trap_cnt_q;
        stall_c    = '0;
        flush_c    = '0;
        redirect_c = 1'b0;

        case (state_q)
            HZ_TRAP: begin
                // Further exceptions are ignored while the pipe drains
                flush_c    = '1;
                trap_cnt_d = trap_cnt_q - CNT_W'(1);
                if (trap_cnt_q <= CNT_W'(1)) begin
                    state_d    = HZ_RUN;
                    trap_cnt_d = '0;
                end
            end

            HZ_RUN, HZ_MEM_WAIT: begin
                // A released bus wait falls straight into the RUN rules
                if (exc_i) begin
                    flush_c    = '1;
                    redirect_c = 1'b1;
                    if (TRAP_MULTI) begin
                        state_d    = HZ_TRAP;
                        trap_cnt_d = TRAP_LOAD;
                    end else begin
                        state_d = HZ_RUN;
                    end
                end else if (mem_busy_i) begin
                    stall_c = '1;
                    state_d = HZ_MEM_WAIT;
                end else begin
                    state_d = HZ_RUN;
                    if (ld_haz_c) begin
                        // ID operand is stale, so any branch decision in ID is discarded too
                        stall_c.if_s = 1'b1;
                        flush_c.id_s = 1'b1;
                    end else if (take_branch_i || take_jump_i) begin
                        flush_c.if_s = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = HZ_RUN;
                trap_cnt_d = '0;
            end
        endcase
    end

    // Controls are forced quiet while reset is asserted
    assign if_stall_o      = rst_i & stall_c.if_s;
    assign id_stall_o      = rst_i & stall_c.id_s;
    assign ex_stall_o      = rst_i & stall_c.ex_s;
    assign mem_stall_o     = rst_i & stall_c.mem_s;
    assign if_flush_o      = rst_i & flush_c.if_s;
    assign id_flush_o      = rst_i & flush_c.id_s;
    assign ex_flush_o      = rst_i & flush_c.ex_s;
    assign mem_flush_o     = rst_i & flush_c.mem_s;
    assign trap_redirect_o = rst_i & redirect_c;

`ifdef TITAN_HAZARD_PERF_EN
    // Saturating count of cycles with the fetch stage held
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (if_stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + PERF_WIDTH'(1);
        end
    end

    // Saturating count of cycles with the fetch stage flushed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flush_cnt_o <= '0;
        end else if (if_flush_o && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + PERF_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_titan_hazard_ctrl.sv
// Self-checking bench for titan_hazard_ctrl.
// The reference model works from the pipeline rules, with a remaining-trap-cycles count and a producer priority list.
// Build with TITAN_HAZARD_PERF_EN to also check the performance counters.
module tb_titan_hazard_ctrl;

    localparam int unsigned N_TRAP = 2;

    logic       clk_i;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_waddr_i, mem_waddr_i, wb_waddr_i;
    logic       ex_we_i, ex_is_load_i, mem_we_i, wb_we_i;
    logic       mem_busy_i, take_branch_i, take_jump_i, exc_i;
    logic [1:0] forward_a_sel_o, forward_b_sel_o;
    logic       if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
    logic       if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
    logic       trap_redirect_o;
`ifdef TITAN_HAZARD_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
    int unsigned stall_ref, flush_ref;
`endif

    int n_cmp;
    int n_err;
    int trap_left;

    titan_hazard_ctrl #(
        .TRAP_FLUSH_CYCLES (N_TRAP)
`ifdef TITAN_HAZARD_PERF_EN
        ,
        .PERF_WIDTH        (32)
`endif
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .ex_waddr_i      (ex_waddr_i),
        .ex_we_i         (ex_we_i),
        .ex_is_load_i    (ex_is_load_i),
        .mem_waddr_i     (mem_waddr_i),
        .mem_we_i        (mem_we_i),
        .wb_waddr_i      (wb_waddr_i),
        .wb_we_i         (wb_we_i),
        .mem_busy_i      (mem_busy_i),
        .take_branch_i   (take_branch_i),
        .take_jump_i     (take_jump_i),
        .exc_i           (exc_i),
        .forward_a_sel_o (forward_a_sel_o),
        .forward_b_sel_o (forward_b_sel_o),
        .if_stall_o      (if_stall_o),
        .id_stall_o      (id_stall_o),
        .ex_stall_o      (ex_stall_o),
        .mem_stall_o     (mem_stall_o),
        .if_flush_o      (if_flush_o),
        .id_flush_o      (id_flush_o),
        .ex_flush_o      (ex_flush_o),
        .mem_flush_o     (mem_flush_o),
        .trap_redirect_o (trap_redirect_o)
`ifdef TITAN_HAZARD_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count one comparison and report it if it disagrees
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest in-flight writer of rs supplies the operand; x0 never forwards
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        logic [4:0] src_addr [3];
        logic       src_we   [3];
        src_addr[0] = ex_waddr_i;  src_we[0] = ex_we_i;
        src_addr[1] = mem_waddr_i; src_we[1] = mem_we_i;
        src_addr[2] = wb_waddr_i;  src_we[2] = wb_we_i;
        if (rs == 5'd0) return 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (src_we[i] && src_addr[i] == rs) return 2'(i + 1);
        end
        return 2'd0;
    endfunction

    // Expected {redirect, flush[if,id,ex,mem], stall[if,id,ex,mem]} for this cycle
    function automatic logic [8:0] ref_ctl();
        logic ld;
        ld = ex_we_i && ex_is_load_i && (ex_waddr_i != 5'd0) &&
             (ex_waddr_i == id_rs1_i || ex_waddr_i == id_rs2_i);
        if (!rst_i)                      return 9'b0_0000_0000;
        if (trap_left > 0)               return 9'b0_1111_0000;
        if (exc_i)                       return 9'b1_1111_0000;
        if (mem_busy_i)                  return 9'b0_0000_1111;
        if (ld)                          return 9'b0_0100_1000;
        if (take_branch_i || take_jump_i) return 9'b0_1000_0000;
        return 9'b0_0000_0000;
    endfunction

    task automatic idle();
        id_rs1_i = 0; id_rs2_i = 0; ex_waddr_i = 0; mem_waddr_i = 0; wb_waddr_i = 0;
        ex_we_i = 0; ex_is_load_i = 0; mem_we_i = 0; wb_we_i = 0;
        mem_busy_i = 0; take_branch_i = 0; take_jump_i = 0; exc_i = 0;
    endtask

    // Inputs are already applied after a negedge; check, then advance the model across posedge
    task automatic step(input string tag);
        logic [8:0] exp;
        #1;
        exp = ref_ctl();
        check({tag, ".fwd_a"}, 32'(forward_a_sel_o), 32'(ref_fwd(id_rs1_i)));
        check({tag, ".fwd_b"}, 32'(forward_b_sel_o), 32'(ref_fwd(id_rs2_i)));
        check({tag, ".stall"}, 32'({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o}), 32'(exp[3:0]));
        check({tag, ".flush"}, 32'({if_flush_o, id_flush_o, ex_flush_o, mem_flush_o}), 32'(exp[7:4]));
        check({tag, ".redir"}, 32'(trap_redirect_o), 32'(exp[8]));
`ifdef TITAN_HAZARD_PERF_EN
        check({tag, ".stall_cnt"}, stall_cnt_o, stall_ref);
        check({tag, ".flush_cnt"}, flush_cnt_o, flush_ref);
`endif
        @(posedge clk_i);
        if (!rst_i) begin
            trap_left = 0;
        end else if (trap_left > 0) begin
            trap_left--;
        end else if (exc_i) begin
            trap_left = N_TRAP - 1;
        end
`ifdef TITAN_HAZARD_PERF_EN
        if (!rst_i) begin
            stall_ref = 0;
            flush_ref = 0;
        end else begin
            if (exp[3]) stall_ref++;
            if (exp[7]) flush_ref++;
        end
`endif
        @(negedge clk_i);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        trap_left = 0;
`ifdef TITAN_HAZARD_PERF_EN
        stall_ref = 0;
        flush_ref = 0;
`endif
        rst_i = 1'b0;
        idle();
        @(negedge clk_i);
        exc_i = 1; mem_busy_i = 1;
        step("reset");
        idle();
        rst_i = 1'b1;

        // Forwarding priority and x0
        ex_we_i = 1; ex_waddr_i = 5; id_rs1_i = 5;
        step("fwd_ex");
        mem_we_i = 1; mem_waddr_i = 5;
        step("fwd_ex_over_mem");
        id_rs1_i = 0; ex_waddr_i = 0;
        step("fwd_x0");
        idle();

        // Load-use bubble, then the load forwards from MEM
        ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 7; id_rs2_i = 7; take_branch_i = 1;
        step("ld_use");
        idle();
        mem_we_i = 1; mem_waddr_i = 7; id_rs2_i = 7;
        step("ld_fwd_mem");
        idle();

        // Three-cycle bus wait, released together with a jump
        mem_busy_i = 1;
        repeat (3) step("bus_wait");
        mem_busy_i = 0; take_jump_i = 1;
        step("bus_release_jump");
        idle();

        // Trap, with a second exception ignored inside TRAP
        exc_i = 1;
        step("trap_enter");
        step("trap_ignore_exc");
        exc_i = 0;
        step("trap_done");

        // Exception beats bus wait
        exc_i = 1; mem_busy_i = 1;
        step("exc_vs_busy");
        exc_i = 0;
        step("trap_busy");
        mem_busy_i = 0;
        step("after_trap");

        // Reset in the middle of TRAP
        exc_i = 1;
        step("trap_enter2");
        exc_i = 0; rst_i = 0;
        step("reset_mid_trap");
        rst_i = 1;
        step("run_after_reset");

        // Randomized traffic with small register numbers to provoke matches
        for (int c = 0; c < 3000; c++) begin
            id_rs1_i      = 5'($urandom_range(0, 7));
            id_rs2_i      = 5'($urandom_range(0, 7));
            ex_waddr_i    = 5'($urandom_range(0, 7));
            mem_waddr_i   = 5'($urandom_range(0, 7));
            wb_waddr_i    = 5'($urandom_range(0, 7));
            ex_we_i       = 1'($urandom_range(0, 1));
            ex_is_load_i  = 1'($urandom_range(0, 2) == 0);
            mem_we_i      = 1'($urandom_range(0, 1));
            wb_we_i       = 1'($urandom_range(0, 1));
            mem_busy_i    = 1'($urandom_range(0, 4) == 0);
            take_branch_i = 1'($urandom_range(0, 3) == 0);
            take_jump_i   = 1'($urandom_range(0, 7) == 0);
            exc_i         = 1'($urandom_range(0, 15) == 0);
            rst_i         = 1'($urandom_range(0, 63) != 0);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/titan_hazard_ctrl.md
Name: titan_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage Titan core. Drives the ID-stage operand forwarding selects and the per-stage stall/flush controls. Detects load-use hazards, freezes the pipe during data-bus waits, kills the wrong-path fetch on taken branches and jumps, and runs a multi-cycle trap flush sequence.

Parameters:
TRAP_FLUSH_CYCLES, 2, cycles all of IF..MEM are flushed after a trap (>=1)
PERF_WIDTH, 32, width of the optional performance counters

Ports:
clk_i  in  1  core clock
rst_i  in  1  reset, asynchronous, active-low
id_rs1_i  in  5  rs1 of the instruction in ID
id_rs2_i  in  5  rs2 of the instruction in ID
ex_waddr_i  in  5  rd of the instruction in EX
ex_we_i  in  1  EX writes rd
ex_is_load_i  in  1  EX holds a load
mem_waddr_i  in  5  rd in MEM
mem_we_i  in  1  MEM writes rd
wb_waddr_i  in  5  rd in WB
wb_we_i  in  1  WB writes rd
mem_busy_i  in  1  data bus has not completed the MEM access
take_branch_i  in  1  branch resolved taken in ID
take_jump_i  in  1  jump in ID
exc_i  in  1  exception/trap raised (single-cycle pulse)
forward_a_sel_o  out  2  0=regfile, 1=EX, 2=MEM, 3=WB
forward_b_sel_o  out  2  same encoding for rs2
if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold stage register
if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  load bubble into stage register
trap_redirect_o  out  1  one-cycle pulse: PC loads the trap vector

Behaviour:
- Forwarding (combinational): for each rs != 0, pick EX if ex_we_i and ex_waddr_i matches, else MEM on match, else WB on match, else 0. rs==0 always gives 0.
- Load-use hazard ld_haz = ex_we_i & ex_is_load_i & ex_waddr_i != 0 & (ex_waddr_i == id_rs1_i | ex_waddr_i == id_rs2_i).
- FSM state register; reset state RUN.
- States:
  - RUN: normal operation.
  - MEM_WAIT: data-bus wait in progress.
  - TRAP: flush sequence, with down-counter trap_cnt (reset 0).
- Priority each cycle: exc_i > mem_busy_i > ld_haz > taken branch/jump.
- RUN:
  - exc_i: assert all four flushes and trap_redirect_o this cycle; go to TRAP with trap_cnt = TRAP_FLUSH_CYCLES-1 (stay in RUN if the value is 0).
  - mem_busy_i: assert all four stalls; go to MEM_WAIT.
  - ld_haz: if_stall_o=1 and id_flush_o=1 (one bubble into EX); take_branch_i/take_jump_i are ignored because the ID operand is invalid.
  - take_branch_i|take_jump_i: if_flush_o=1.
- MEM_WAIT:
  - All four stalls held while mem_busy_i=1.
  - When mem_busy_i drops: return to RUN and evaluate the RUN rules in the same cycle (no dead cycle).
  - exc_i during the wait: take the RUN exc_i action.
- TRAP:
  - All four flushes asserted; stalls are 0.
  - Decrement trap_cnt; go to RUN when trap_cnt reaches 0.
  - exc_i inside TRAP is ignored.
- Stall and flush are never both 1 for one stage. When they conflict, flush wins for exceptions and stall wins otherwise.
- Reset values: all stalls/flushes/trap_redirect_o = 0. Forward selects follow the inputs (combinational).
- Reset asserted mid-sequence returns to RUN immediately and clears trap_cnt.
- Stall/flush outputs are a combinational decode of state + inputs. No registered output latency.

Optional Feature:
TITAN_HAZARD_PERF_EN:
- Defined: adds outputs stall_cnt_o and flush_cnt_o [PERF_WIDTH-1:0], both reset to 0.
  - stall_cnt_o: +1 each cycle if_stall_o=1.
  - flush_cnt_o: +1 each cycle if_flush_o=1.
  - Both saturate at all-ones.
- Undefined: ports and counters absent; zero area.

Decomposition:
- Shared package/def file:
  - Forward-select encodings: FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3.
  - FSM state encodings: HZ_RUN, HZ_MEM_WAIT, HZ_TRAP.
- One sub-module titan_fwd_sel: per-operand match/priority logic, instantiated twice (rs1, rs2).
- FSM and counters stay in titan_hazard_ctrl.

Test Plan:
- ex_we_i=1, ex_waddr_i=5, id_rs1_i=5, no load -> forward_a_sel_o=1. Same with mem_waddr_i=5 also matching -> still 1. Then rs1=0 with ex_waddr_i=0 -> 0.
- Load to x7 in EX, id_rs2_i=7 -> exactly one cycle of if_stall_o=1, id_flush_o=1. Next cycle (load in MEM) forward_b_sel_o=2 and no stall.
- mem_busy_i high 3 cycles -> all stalls=1 for 3 cycles, state MEM_WAIT. On release the same cycle's take_jump_i=1 -> if_flush_o=1.
- exc_i pulse with TRAP_FLUSH_CYCLES=2 -> trap_redirect_o 1 cycle; all flushes for 2 cycles total. Second exc_i in TRAP is ignored.
- exc_i and mem_busy_i same cycle -> flushes win, no stalls, enters TRAP.
- Reset (rst_i=0) mid-TRAP -> outputs 0 at once, RUN after release. With TITAN_HAZARD_PERF_EN: a load-use hazard gives stall_cnt_o=1, and a taken branch gives flush_cnt_o=1.
